sodor_lb_lockstep_monitor: RTL and testbench
============================================

// Module: sodor_lb_lockstep_monitor
// PURPOSE
//  Two-copy lockstep monitor for Sodor5 load-buffer non-interference checks. Sequences the core
//  reset for both copies and flags the architectural-equality sync window. Compares every entry of
//  the two load-buffer tables each cycle and keeps sticky divergence plus first-divergence info.
//  Fires a single pass/fail check at a programmed cycle. Sits in the formal/sim harness between two CoreTop copies.
// PARAMETERS
//  NUM_ENTRIES   4   load-buffer table entries per copy (>=1)
//  ADDR_W        32  entry address width
//  DATA_W        32  entry data width
//  RESET_CYCLES  2   cycles core_reset is held high after harness reset release (>=1)
//  SYNC_CYCLE    2   cycle index of the sync window (>=RESET_CYCLES)
//  CHECK_CYCLE   20  cycle index of the verdict (>SYNC_CYCLE, <2**CNT_W-1)
//  CNT_W         6   cycle counter width
// PORTS
//  clk            in   1                   clock
//  reset          in   1                   synchronous, active-high harness reset
//  arch_eq        in   1                   regfile copy A == copy B (sampled in sync window)
//  lb_valid_a     in   NUM_ENTRIES         copy A entry valid bits
//  lb_addr_a      in   NUM_ENTRIES*ADDR_W  copy A entry addresses, entry i at [i*ADDR_W +: ADDR_W]
//  lb_data_a      in   NUM_ENTRIES*DATA_W  copy A entry data
//  lb_valid_b/lb_addr_b/lb_data_b  in  same widths as copy A  copy B
//  core_reset     out  1                   reset driven to both cores
//  sync_window    out  1                   one-cycle pulse; harness constrains regfiles equal here
//  diverge_now    out  1                   combinational: any entry diverges this cycle (RUN only)
//  diverge_sticky out  1                   a divergence occurred since the sync window
//  first_cycle    out  CNT_W               cycle index of the first divergence
//  first_entry    out  $clog2(NUM_ENTRIES) lowest diverging entry index at first divergence
//  precond_fail   out  1                   arch_eq was low in the sync window
//  check_fire     out  1                   one-cycle pulse at CHECK_CYCLE
//  check_pass     out  1                   valid with check_fire: !diverge_sticky && !precond_fail
//  done           out  1                   high after the check until reset
// BEHAVIOUR
//  - Reset: cyc=0, state=S_RESET, core_reset=1. All other outputs 0, including sticky/first_*/precond_fail.
//  - cyc increments every non-reset cycle and saturates at all-ones.
//  - FSM states:
//    S_RESET: core_reset=1. Go to S_WAIT when cyc==RESET_CYCLES-1.
//    S_WAIT: core_reset=0. Go to S_SYNC when cyc==SYNC_CYCLE-1. Skip S_WAIT when SYNC_CYCLE==RESET_CYCLES.
//    S_SYNC: one cycle, sync_window=1. precond_fail<=!arch_eq. Go to S_RUN.
//    S_RUN: compare each cycle. At cyc==CHECK_CYCLE-1 go to S_CHECK.
//    S_CHECK: one cycle. check_fire=1 and check_pass driven combinationally from regs updated through
//      the previous cycle, plus this cycle's diverge_now. Go to S_DONE.
//    S_DONE: done=1. Freeze all flags and ignore inputs.
//  - Entry i diverges if valid_a[i]^valid_b[i], or both valid and addr_a[i]!=addr_b[i].
//    Invalid entries' addr/data are don't-care.
//  - Compare only in S_RUN and S_CHECK. diverge_now=0 in every other state.
//  - First divergence (sticky 0->1): capture first_cycle=cyc and first_entry=lowest diverging index.
//    Later divergences never overwrite these. Simultaneous multi-entry divergence takes the lowest index.
//  - reset asserted in any state, including mid-RUN or DONE, returns to the reset values next cycle.
// CONFIGURATION
//  LB_DATA_CHECK_EN defined: entry also diverges if both valid and data_a[i]!=data_b[i].
//  LB_DATA_CHECK_EN undefined: data ports unused and ignored (address/valid check only).
// STRUCTURE
//  sodor_verif_pkg: mon_state_e (S_RESET,S_WAIT,S_SYNC,S_RUN,S_CHECK,S_DONE), lb_entry_t {valid,addr,data}.
//  Submodule lb_entry_cmp: one entry pair -> diverge bit, carries the LB_DATA_CHECK_EN guard.
//  Instantiated NUM_ENTRIES times by generate. Top holds FSM, counter, priority encoder, sticky regs.
// TESTING
//  1. Identical tables, arch_eq=1 -> check_fire at cyc 20, check_pass=1, diverge_sticky=0, done=1 after.
//  2. Cyc 9: valid_a[2]=1, valid_b[2]=0 -> sticky=1, first_cycle=9, first_entry=2, check_pass=0.
//  3. Cyc 7: entries 1 and 3 both valid, addr_a=0x64 vs addr_b=0x68 in both -> first_entry=1.
//     Second divergence at cyc 12 leaves first_cycle=7.
//  4. Entry 0 both valid, same addr, data 0x11 vs 0x22 -> fail with LB_DATA_CHECK_EN defined, pass without.
//  5. arch_eq=0 at cyc 2, no divergence -> precond_fail=1, check_pass=0.
//  6. Diverge at cyc 5, reset at cyc 10 -> all flags 0, core_reset=1 for 2 cycles, full rerun passes.

Source files
------------

// File: rtl/sodor_verif_pkg.sv
// Purpose: shared types for the Sodor5 load-buffer lockstep monitor.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: mon_state_e (monitor FSM states) and lb_entry_t (one load-buffer
// entry). Entry fields are sized to LB_MAX_W. Narrower tables are zero-extended
// into them, which leaves the results of equality compares unchanged.
package sodor_verif_pkg;

  localparam int LB_MAX_W = 64;

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_SYNC,
    S_RUN,
    S_CHECK,
    S_DONE
  } mon_state_e;

  typedef struct packed {
    logic                valid;
    logic [LB_MAX_W-1:0] addr;
    logic [LB_MAX_W-1:0] data;
  } lb_entry_t;

endpackage

// File: rtl/sodor_lb_lockstep_monitor_lb_entry_cmp.sv
// Purpose: compares one load-buffer entry pair (copy A vs copy B).
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: i_a, i_b  entries from copy A and copy B
//        o_diverge asserted when a valid mismatch exists, or when both entries
//                  are valid and their address differs (their data is also
//                  compared under LB_DATA_CHECK_EN).
// Config macro: LB_DATA_CHECK_EN adds the data compare for valid entry pairs.
module lb_entry_cmp
  import sodor_verif_pkg::*;
(
  input  lb_entry_t i_a,
  input  lb_entry_t i_b,
  output logic      o_diverge
);

  logic w_valid_mismatch;
  logic w_both_valid;

  assign w_valid_mismatch = i_a.valid ^ i_b.valid;
  assign w_both_valid     = i_a.valid & i_b.valid;

`ifdef LB_DATA_CHECK_EN
  assign o_diverge = w_valid_mismatch |
                     (w_both_valid & ((i_a.addr != i_b.addr) | (i_a.data != i_b.data)));
`else
  // The data fields are not part of the check in this build.
  logic w_unused_data;
  assign w_unused_data = ^{i_a.data, i_b.data};
  assign o_diverge = w_valid_mismatch | (w_both_valid & (i_a.addr != i_b.addr));
`endif

endmodule

// File: rtl/sodor_lb_lockstep_monitor.sv
// Purpose: two-copy lockstep monitor. It sequences core reset, flags the sync
//          window, tracks load-buffer divergence, and issues one pass/fail verdict.
// Latency: o_diverge_now and o_check_pass are combinational. The sticky and
//          first-divergence outputs are registered one cycle after the divergence.
// Backpressure: none. The monitor observes only and never stalls either copy.
// Ports: i_clk, i_reset (sync, active-high); i_arch_eq; i_lb_{valid,addr,data}_{a,b}
//        (entry i at [i*W +: W]); o_core_reset, o_sync_window, o_diverge_now,
//        o_diverge_sticky, o_first_cycle, o_first_entry, o_precond_fail,
//        o_check_fire, o_check_pass, o_done.
// Config macro: LB_DATA_CHECK_EN (see lb_entry_cmp).
module sodor_lb_lockstep_monitor
  import sodor_verif_pkg::*;
#(
  parameter int NUM_ENTRIES  = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RESET_CYCLES = 2,
  parameter int SYNC_CYCLE   = 2,
  parameter int CHECK_CYCLE  = 20,
  parameter int CNT_W        = 6,
  localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_arch_eq,
  input  logic [NUM_ENTRIES-1:0]        i_lb_valid_a,
  input  logic [NUM_ENTRIES*ADDR_W-1:0] i_lb_addr_a,
  input  logic [NUM_ENTRIES*DATA_W-1:0] i_lb_data_a,
  input  logic [NUM_ENTRIES-1:0]        i_lb_valid_b,
  input  logic [NUM_ENTRIES*ADDR_W-1:0] i_lb_addr_b,
  input  logic [NUM_ENTRIES*DATA_W-1:0] i_lb_data_b,
  output logic                          o_core_reset,
  output logic                          o_sync_window,
  output logic                          o_diverge_now,
  output logic                          o_diverge_sticky,
  output logic [CNT_W-1:0]              o_first_cycle,
  output logic [IDX_W-1:0]              o_first_entry,
  output logic                          o_precond_fail,
  output logic                          o_check_fire,
  output logic                          o_check_pass,
  output logic                          o_done
);

  localparam logic [CNT_W-1:0] C_RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SYNC_PREV  = CNT_W'(SYNC_CYCLE - 1);
  localparam logic [CNT_W-1:0] C_CHECK_PREV = CNT_W'(CHECK_CYCLE - 1);

  mon_state_e           r_state;
  mon_state_e           w_state_nxt;
  logic [CNT_W-1:0]     r_cyc;
  logic                 r_sticky;
  logic [CNT_W-1:0]     r_first_cycle;
  logic [IDX_W-1:0]     r_first_entry;
  logic                 r_precond_fail;

  lb_entry_t            w_ent_a [NUM_ENTRIES];
  lb_entry_t            w_ent_b [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_div;
  logic [IDX_W-1:0]     w_first_idx;
  logic                 w_compare_en;
  logic                 w_diverge_now;

  // Zero-extend each flattened entry into the shared entry type.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_ent_a[i] = '0;
      w_ent_b[i] = '0;
      w_ent_a[i].valid = i_lb_valid_a[i];
      w_ent_b[i].valid = i_lb_valid_b[i];
      w_ent_a[i].addr[ADDR_W-1:0] = i_lb_addr_a[i*ADDR_W +: ADDR_W];
      w_ent_b[i].addr[ADDR_W-1:0] = i_lb_addr_b[i*ADDR_W +: ADDR_W];
      w_ent_a[i].data[DATA_W-1:0] = i_lb_data_a[i*DATA_W +: DATA_W];
      w_ent_b[i].data[DATA_W-1:0] = i_lb_data_b[i*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cmp
    lb_entry_cmp u_cmp (
      .i_a       (w_ent_a[g]),
      .i_b       (w_ent_b[g]),
      .o_diverge (w_div[g])
    );
  end

  // Scan from the top index downwards so that the lowest diverging entry is
  // the one that is kept.
  always_comb begin
    w_first_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_div[i]) w_first_idx = IDX_W'(i);
    end
  end

  assign w_compare_en  = (r_state == S_RUN) || (r_state == S_CHECK);
  assign w_diverge_now = w_compare_en && (|w_div);

  // Cycle counter: it counts from harness reset release and holds at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cyc <= '0;
    end else if (r_cyc != '1) begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_RESET;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RESET: begin
        if (r_cyc == C_RESET_LAST) begin
          // If the sync cycle comes right after core reset, there is no wait phase.
          w_state_nxt = (SYNC_CYCLE == RESET_CYCLES) ? S_SYNC : S_WAIT;
        end
      end
      S_WAIT:  if (r_cyc == C_SYNC_PREV)  w_state_nxt = S_SYNC;
      S_SYNC:  w_state_nxt = S_RUN;
      S_RUN:   if (r_cyc == C_CHECK_PREV) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Sticky divergence, first-divergence capture, and the precondition flag.
  // Because comparison is gated off in S_DONE, these registers hold their
  // values after the verdict.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sticky       <= 1'b0;
      r_first_cycle  <= '0;
      r_first_entry  <= '0;
      r_precond_fail <= 1'b0;
    end else begin
      if (r_state == S_SYNC) r_precond_fail <= !i_arch_eq;
      if (w_diverge_now && !r_sticky) begin
        r_sticky      <= 1'b1;
        r_first_cycle <= r_cyc;
        r_first_entry <= w_first_idx;
      end
    end
  end

  assign o_core_reset     = (r_state == S_RESET);
  assign o_sync_window    = (r_state == S_SYNC);
  assign o_diverge_now    = w_diverge_now;
  assign o_diverge_sticky = r_sticky;
  assign o_first_cycle    = r_first_cycle;
  assign o_first_entry    = r_first_entry;
  assign o_precond_fail   = r_precond_fail;
  assign o_check_fire     = (r_state == S_CHECK);
  // A divergence in the verdict cycle itself still fails the check.
  assign o_check_pass     = (r_state == S_CHECK) && !r_sticky && !w_diverge_now && !r_precond_fail;
  assign o_done           = (r_state == S_DONE);

endmodule

// File: tb/tb_sodor_lb_lockstep_monitor.sv
// Purpose: directed self-checking bench for sodor_lb_lockstep_monitor (default parameters).
// Latency: n/a.
// Backpressure: n/a.
module tb_sodor_lb_lockstep_monitor;

  localparam int NE = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            i_clk;
  logic            i_reset;
  logic            i_arch_eq;
  logic [NE-1:0]   i_lb_valid_a, i_lb_valid_b;
  logic [NE*AW-1:0] i_lb_addr_a, i_lb_addr_b;
  logic [NE*DW-1:0] i_lb_data_a, i_lb_data_b;
  logic            o_core_reset, o_sync_window, o_diverge_now, o_diverge_sticky;
  logic [5:0]      o_first_cycle;
  logic [1:0]      o_first_entry;
  logic            o_precond_fail, o_check_fire, o_check_pass, o_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_now  = 0;

  sodor_lb_lockstep_monitor dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_arch_eq(i_arch_eq),
    .i_lb_valid_a(i_lb_valid_a), .i_lb_addr_a(i_lb_addr_a), .i_lb_data_a(i_lb_data_a),
    .i_lb_valid_b(i_lb_valid_b), .i_lb_addr_b(i_lb_addr_b), .i_lb_data_b(i_lb_data_b),
    .o_core_reset(o_core_reset), .o_sync_window(o_sync_window),
    .o_diverge_now(o_diverge_now), .o_diverge_sticky(o_diverge_sticky),
    .o_first_cycle(o_first_cycle), .o_first_entry(o_first_entry),
    .o_precond_fail(o_precond_fail), .o_check_fire(o_check_fire),
    .o_check_pass(o_check_pass), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc_now++;
  endtask

  task automatic goto_cyc(input int k);
    for (int n = 0; n < 100 && cyc_now < k; n++) step();
  endtask

  task automatic set_identical();
    i_arch_eq    = 1'b1;
    i_lb_valid_a = 4'hF;
    i_lb_valid_b = 4'hF;
    for (int i = 0; i < NE; i++) begin
      i_lb_addr_a[i*AW +: AW] = 32'h1000 + 32'(i * 4);
      i_lb_addr_b[i*AW +: AW] = 32'h1000 + 32'(i * 4);
      i_lb_data_a[i*DW +: DW] = 32'hA0 + 32'(i);
      i_lb_data_b[i*DW +: DW] = 32'hA0 + 32'(i);
    end
  endtask

  // Assert reset for one cycle, then release it. The bench is left at cyc 0.
  task automatic do_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    cyc_now = 0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    set_identical();
    i_lb_valid_b = 4'h0;
    step();
    step();
    n_checks++; if (o_core_reset !== 1'b1) begin n_errors++; $display("FAIL rst_core_reset got=%0b exp=1", o_core_reset); end
    n_checks++; if (o_sync_window !== 1'b0) begin n_errors++; $display("FAIL rst_sync_window got=%0b exp=0", o_sync_window); end
    n_checks++; if (o_diverge_now !== 1'b0) begin n_errors++; $display("FAIL rst_diverge_now got=%0b exp=0", o_diverge_now); end
    n_checks++; if (o_diverge_sticky !== 1'b0) begin n_errors++; $display("FAIL rst_sticky got=%0b exp=0", o_diverge_sticky); end
    n_checks++; if (o_first_cycle !== 6'd0) begin n_errors++; $display("FAIL rst_first_cycle got=%0d exp=0", o_first_cycle); end
    n_checks++; if (o_first_entry !== 2'd0) begin n_errors++; $display("FAIL rst_first_entry got=%0d exp=0", o_first_entry); end
    n_checks++; if (o_precond_fail !== 1'b0) begin n_errors++; $display("FAIL rst_precond got=%0b exp=0", o_precond_fail); end
    n_checks++; if ({o_check_fire, o_check_pass, o_done} !== 3'b000) begin n_errors++; $display("FAIL rst_fire_pass_done got=%b exp=000", {o_check_fire, o_check_pass, o_done}); end
    i_reset = 1'b0;
    cyc_now = 0;
    set_identical();
  endtask

  // Identical tables give a pass at cyc 20. Divergent inputs that appear
  // outside RUN/CHECK are not compared.
  task automatic test_nominal();
    do_reset();
    set_identical();
    n_checks++; if (o_core_reset !== 1'b1) begin n_errors++; $display("FAIL nom_core_reset_c0 got=%0b exp=1", o_core_reset); end
    step();
    i_lb_valid_a = 4'hE; #1;
    n_checks++; if (o_diverge_now !== 1'b0) begin n_errors++; $display("FAIL nom_no_cmp_in_reset got=%0b exp=0", o_diverge_now); end
    n_checks++; if (o_core_reset !== 1'b1) begin n_errors++; $display("FAIL nom_core_reset_c1 got=%0b exp=1", o_core_reset); end
    step();
    n_checks++; if ({o_core_reset, o_sync_window} !== 2'b01) begin n_errors++; $display("FAIL nom_sync_c2 got=%b exp=01", {o_core_reset, o_sync_window}); end
    n_checks++; if (o_diverge_now !== 1'b0) begin n_errors++; $display("FAIL nom_no_cmp_in_sync got=%0b exp=0", o_diverge_now); end
    step();
    set_identical();
    i_arch_eq = 1'b0; #1;
    n_checks++; if (o_sync_window !== 1'b0) begin n_errors++; $display("FAIL nom_sync_pulse_c3 got=%0b exp=0", o_sync_window); end
    goto_cyc(19);
    n_checks++; if (o_check_fire !== 1'b0) begin n_errors++; $display("FAIL nom_fire_c19 got=%0b exp=0", o_check_fire); end
    goto_cyc(20);
    n_checks++; if ({o_check_fire, o_check_pass} !== 2'b11) begin n_errors++; $display("FAIL nom_verdict_c20 got=%b exp=11", {o_check_fire, o_check_pass}); end
    n_checks++; if ({o_diverge_sticky, o_precond_fail, o_done} !== 3'b000) begin n_errors++; $display("FAIL nom_flags_c20 got=%b exp=000", {o_diverge_sticky, o_precond_fail, o_done}); end
    step();
    n_checks++; if ({o_check_fire, o_done} !== 2'b01) begin n_errors++; $display("FAIL nom_done_c21 got=%b exp=01", {o_check_fire, o_done}); end
    i_lb_valid_b = 4'h0; #1;
    n_checks++; if (o_diverge_now !== 1'b0) begin n_errors++; $display("FAIL nom_no_cmp_in_done got=%0b exp=0", o_diverge_now); end
    step();
    n_checks++; if ({o_diverge_sticky, o_done} !== 2'b01) begin n_errors++; $display("FAIL nom_frozen_c22 got=%b exp=01", {o_diverge_sticky, o_done}); end
  endtask

  task automatic test_single_div();
    do_reset();
    set_identical();
    goto_cyc(9);
    i_lb_valid_b[2] = 1'b0; #1;
    n_checks++; if (o_diverge_now !== 1'b1) begin n_errors++; $display("FAIL single_now got=%0b exp=1", o_diverge_now); end
    step();
    set_identical(); #1;
    n_checks++; if (o_diverge_sticky !== 1'b1) begin n_errors++; $display("FAIL single_sticky got=%0b exp=1", o_diverge_sticky); end
    n_checks++; if (o_first_cycle !== 6'd9) begin n_errors++; $display("FAIL single_first_cycle got=%0d exp=9", o_first_cycle); end
    n_checks++; if (o_first_entry !== 2'd2) begin n_errors++; $display("FAIL single_first_entry got=%0d exp=2", o_first_entry); end
    n_checks++; if (o_diverge_now !== 1'b0) begin n_errors++; $display("FAIL single_now_cleared got=%0b exp=0", o_diverge_now); end
    goto_cyc(20);
    n_checks++; if ({o_check_fire, o_check_pass} !== 2'b10) begin n_errors++; $display("FAIL single_verdict got=%b exp=10", {o_check_fire, o_check_pass}); end
  endtask

  task automatic test_multi_div();
    do_reset();
    set_identical();
    goto_cyc(7);
    i_lb_addr_a[1*AW +: AW] = 32'h64; i_lb_addr_b[1*AW +: AW] = 32'h68;
    i_lb_addr_a[3*AW +: AW] = 32'h64; i_lb_addr_b[3*AW +: AW] = 32'h68;
    #1;
    n_checks++; if (o_diverge_now !== 1'b1) begin n_errors++; $display("FAIL multi_now got=%0b exp=1", o_diverge_now); end
    step();
    set_identical();
    n_checks++; if ({o_first_cycle, o_first_entry} !== {6'd7, 2'd1}) begin n_errors++; $display("FAIL multi_first got=%0d/%0d exp=7/1", o_first_cycle, o_first_entry); end
    goto_cyc(12);
    i_lb_valid_a[0] = 1'b0; #1;
    n_checks++; if (o_diverge_now !== 1'b1) begin n_errors++; $display("FAIL multi_second_now got=%0b exp=1", o_diverge_now); end
    step();
    set_identical();
    n_checks++; if ({o_first_cycle, o_first_entry} !== {6'd7, 2'd1}) begin n_errors++; $display("FAIL multi_kept got=%0d/%0d exp=7/1", o_first_cycle, o_first_entry); end
    goto_cyc(20);
    n_checks++; if ({o_check_fire, o_check_pass} !== 2'b10) begin n_errors++; $display("FAIL multi_verdict got=%b exp=10", {o_check_fire, o_check_pass}); end
  endtask

  task automatic test_data_only();
    logic exp_pass;
`ifdef LB_DATA_CHECK_EN
    exp_pass = 1'b0;
`else
    exp_pass = 1'b1;
`endif
    do_reset();
    set_identical();
    i_lb_data_a[0 +: DW] = 32'h11;
    i_lb_data_b[0 +: DW] = 32'h22;
    goto_cyc(5);
    n_checks++; if (o_diverge_now !== !exp_pass) begin n_errors++; $display("FAIL data_now got=%0b exp=%0b", o_diverge_now, !exp_pass); end
    goto_cyc(20);
    n_checks++; if ({o_check_fire, o_check_pass} !== {1'b1, exp_pass}) begin n_errors++; $display("FAIL data_verdict got=%b exp=1%0b", {o_check_fire, o_check_pass}, exp_pass); end
  endtask

  task automatic test_precond();
    do_reset();
    set_identical();
    goto_cyc(2);
    i_arch_eq = 1'b0;
    step();
    i_arch_eq = 1'b1;
    n_checks++; if (o_precond_fail !== 1'b1) begin n_errors++; $display("FAIL precond_flag got=%0b exp=1", o_precond_fail); end
    goto_cyc(20);
    n_checks++; if ({o_check_fire, o_check_pass, o_diverge_sticky} !== 3'b100) begin n_errors++; $display("FAIL precond_verdict got=%b exp=100", {o_check_fire, o_check_pass, o_diverge_sticky}); end
  endtask

  // A divergence in the verdict cycle itself must fail the check.
  task automatic test_check_edge();
    do_reset();
    set_identical();
    goto_cyc(20);
    i_lb_addr_b[2*AW +: AW] = 32'hDEAD; #1;
    n_checks++; if ({o_check_fire, o_check_pass, o_diverge_now} !== 3'b101) begin n_errors++; $display("FAIL edge_verdict got=%b exp=101", {o_check_fire, o_check_pass, o_diverge_now}); end
    set_identical();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_identical();
    goto_cyc(5);
    i_lb_valid_a[3] = 1'b0;
    step();
    set_identical();
    n_checks++; if ({o_diverge_sticky, o_first_cycle, o_first_entry} !== {1'b1, 6'd5, 2'd3}) begin n_errors++; $display("FAIL b2b_first got=%b/%0d/%0d exp=1/5/3", o_diverge_sticky, o_first_cycle, o_first_entry); end
    goto_cyc(10);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    cyc_now = 0;
    n_checks++; if ({o_diverge_sticky, o_first_cycle, o_first_entry, o_precond_fail} !== 10'd0) begin n_errors++; $display("FAIL b2b_flags_cleared got=%b/%0d/%0d/%b exp=0/0/0/0", o_diverge_sticky, o_first_cycle, o_first_entry, o_precond_fail); end
    n_checks++; if (o_core_reset !== 1'b1) begin n_errors++; $display("FAIL b2b_core_reset_c0 got=%0b exp=1", o_core_reset); end
    step();
    n_checks++; if (o_core_reset !== 1'b1) begin n_errors++; $display("FAIL b2b_core_reset_c1 got=%0b exp=1", o_core_reset); end
    step();
    n_checks++; if ({o_core_reset, o_sync_window} !== 2'b01) begin n_errors++; $display("FAIL b2b_sync_c2 got=%b exp=01", {o_core_reset, o_sync_window}); end
    goto_cyc(20);
    n_checks++; if ({o_check_fire, o_check_pass} !== 2'b11) begin n_errors++; $display("FAIL b2b_rerun_verdict got=%b exp=11", {o_check_fire, o_check_pass}); end
    step();
    n_checks++; if (o_done !== 1'b1) begin n_errors++; $display("FAIL b2b_done got=%0b exp=1", o_done); end
  endtask

  initial begin
    i_reset = 1'b1;
    set_identical();
    test_reset();
    test_nominal();
    test_reset();
    test_single_div();
    test_multi_div();
    test_data_only();
    test_precond();
    test_check_edge();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
